// File: rtl/dram_cmd_scheduler.sv
// DDR5 command sequencer: one access at a time, ACT0/ACT1 -> CAS0/CAS1 -> PRE with timing down-counters.
// Define OPEN_PAGE_EN to leave the row open after an access and skip PRE/ACT on a row hit.
module dram_cmd_scheduler #(
    parameter int unsigned T_RCD   = 39,
    parameter int unsigned T_CL    = 40,
    parameter int unsigned T_CWL   = 38,
    parameter int unsigned T_BURST = 8,
    parameter int unsigned T_WR    = 30,
    parameter int unsigned T_RP    = 39
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [35:0] req_addr,
    output logic        cmd_valid,
    output logic [2:0]  cmd_type,
    output logic        cmd_channel,
    output logic [2:0]  cmd_bg,
    output logic [1:0]  cmd_bank,
    output logic [15:0] cmd_row,
    output logic [9:0]  cmd_col,
    output logic        done,
    output logic        err
);
    localparam int unsigned CNT_W = 8;
    localparam int unsigned FLD_W = 32;   // {channel, bg, bank, row, col}
    localparam int unsigned TAG_W = 22;   // {channel, bg, bank, row}

    typedef enum logic [3:0] {
        S_IDLE, S_ACT0, S_ACT1, S_WAIT_RCD, S_CAS0, S_CAS1,
        S_WAIT_DATA, S_PRE, S_WAIT_RP, S_IDLE_OPEN
    } state_t;

    localparam logic [2:0] CMD_ACT0 = 3'd0;
    localparam logic [2:0] CMD_ACT1 = 3'd1;
    localparam logic [2:0] CMD_RD0  = 3'd2;
    localparam logic [2:0] CMD_RD1  = 3'd3;
    localparam logic [2:0] CMD_WR0  = 3'd4;
    localparam logic [2:0] CMD_WR1  = 3'd5;
    localparam logic [2:0] CMD_PRE  = 3'd6;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       phase_q, phase_d;
    logic [FLD_W-1:0] fld_q, fld_d;
    logic             wr_q, wr_d;
    logic             accept, illegal, legal;
    logic [FLD_W-1:0] req_fld;
    logic             cmd_valid_d;
    logic [2:0]       cmd_type_d;
    logic [FLD_W-1:0] cmd_fld_d;
    logic             done_d, ready_d;
    logic             unused_addr_bits;
`ifdef OPEN_PAGE_EN
    logic             open_vld_q, open_vld_d;
    logic [TAG_W-1:0] open_tag_q, open_tag_d;
    logic             miss_q, miss_d;
    logic             hit;
`endif

    // Post-CAS wait is split into phases so each fits in the 8-bit counter.
    function automatic logic [CNT_W-1:0] phase_len(input logic [1:0] ph, input logic wr);
        case (ph)
            2'd0:    phase_len = wr ? CNT_W'(T_CWL) : CNT_W'(T_CL);
            2'd1:    phase_len = CNT_W'(T_BURST);
            default: phase_len = CNT_W'(T_WR);
        endcase
    endfunction

    assign unused_addr_bits = ^{req_addr[35:34], req_addr[1:0]};
    assign req_fld = {req_addr[6], req_addr[9:7], req_addr[11:10], req_addr[33:18],
                      req_addr[17:12], req_addr[5:2]};
    assign accept  = req_valid && req_ready;
    assign illegal = accept && (req_op == 2'd3);
    assign legal   = accept && (req_op != 2'd3);
`ifdef OPEN_PAGE_EN
    assign hit = open_vld_q && (req_fld[FLD_W-1 -: TAG_W] == open_tag_q);
`endif

    // Next-state, counters and registered-output precompute.
    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - CNT_W'(1);
        phase_d = phase_q;
        fld_d   = fld_q;
        wr_d    = wr_q;
        done_d  = 1'b0;
`ifdef OPEN_PAGE_EN
        open_vld_d = open_vld_q;
        open_tag_d = open_tag_q;
        miss_d     = miss_q;
`endif
        if (legal) begin
            fld_d = req_fld;
            wr_d  = (req_op == 2'd1);
        end
        unique case (state_q)
            S_IDLE: if (legal) state_d = S_ACT0;
            S_ACT0: begin
                state_d = S_ACT1;
                cnt_d   = CNT_W'(T_RCD);
            end
            S_ACT1, S_WAIT_RCD: state_d = (cnt_q <= CNT_W'(1)) ? S_CAS0 : S_WAIT_RCD;
            S_CAS0: begin
                state_d = S_CAS1;
                cnt_d   = phase_len(2'd0, wr_q);
                phase_d = 2'd0;
            end
            S_CAS1, S_WAIT_DATA: begin
                state_d = S_WAIT_DATA;
                if (cnt_q <= CNT_W'(1)) begin
                    if (phase_q == (wr_q ? 2'd2 : 2'd1)) begin
`ifdef OPEN_PAGE_EN
                        state_d    = S_IDLE_OPEN;
                        done_d     = 1'b1;
                        open_vld_d = 1'b1;
                        open_tag_d = fld_q[FLD_W-1 -: TAG_W];
`else
                        state_d = S_PRE;
                        cnt_d   = CNT_W'(T_RP);
`endif
                    end else begin
                        phase_d = phase_q + 2'd1;
                        cnt_d   = phase_len(phase_q + 2'd1, wr_q);
                    end
                end
            end
            S_PRE, S_WAIT_RP: begin
                state_d = S_WAIT_RP;
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
`ifdef OPEN_PAGE_EN
                    if (miss_q) begin
                        state_d = S_ACT0;
                        done_d  = 1'b0;
                        miss_d  = 1'b0;
                    end
`endif
                end
            end
`ifdef OPEN_PAGE_EN
            S_IDLE_OPEN: begin
                if (legal && hit) begin
                    state_d = S_CAS0;
                end else if (legal) begin
                    state_d    = S_PRE;
                    cnt_d      = CNT_W'(T_RP);
                    miss_d     = 1'b1;
                    open_vld_d = 1'b0;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        cmd_valid_d = 1'b1;
        cmd_type_d  = 3'd0;
        cmd_fld_d   = '0;
        unique case (state_d)
            S_ACT0:  cmd_type_d = CMD_ACT0;
            S_ACT1:  cmd_type_d = CMD_ACT1;
            S_CAS0:  cmd_type_d = wr_d ? CMD_WR0 : CMD_RD0;
            S_CAS1:  cmd_type_d = wr_d ? CMD_WR1 : CMD_RD1;
            S_PRE:   cmd_type_d = CMD_PRE;
            default: cmd_valid_d = 1'b0;
        endcase
        if (cmd_valid_d) cmd_fld_d = fld_d;
`ifdef OPEN_PAGE_EN
        // A miss precharges the bank that is open, not the one just requested.
        if (state_d == S_PRE && miss_d) cmd_fld_d = {open_tag_q, 10'd0};
        ready_d = (state_d == S_IDLE || state_d == S_IDLE_OPEN) && !illegal;
`else
        ready_d = (state_d == S_IDLE) && !illegal;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            phase_q   <= 2'd0;
            fld_q     <= '0;
            wr_q      <= 1'b0;
            req_ready <= 1'b0;
            cmd_valid <= 1'b0;
            cmd_type  <= 3'd0;
            {cmd_channel, cmd_bg, cmd_bank, cmd_row, cmd_col} <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
`ifdef OPEN_PAGE_EN
            open_vld_q <= 1'b0;
            open_tag_q <= '0;
            miss_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            phase_q   <= phase_d;
            fld_q     <= fld_d;
            wr_q      <= wr_d;
            req_ready <= ready_d;
            cmd_valid <= cmd_valid_d;
            cmd_type  <= cmd_type_d;
            {cmd_channel, cmd_bg, cmd_bank, cmd_row, cmd_col} <= cmd_fld_d;
            done      <= done_d;
            err       <= illegal;
`ifdef OPEN_PAGE_EN
            open_vld_q <= open_vld_d;
            open_tag_q <= open_tag_d;
            miss_q     <= miss_d;
`endif
        end
    end
endmodule

// File: tb/tb_dram_cmd_scheduler.sv
// Scoreboard bench for dram_cmd_scheduler (closed-page build): expected command/done/err
// events are computed from the timing rules at accept time and matched by a negedge monitor.
module tb_dram_cmd_scheduler;
    localparam int T_RCD = 39, T_CL = 40, T_CWL = 38, T_BURST = 8, T_WR = 30, T_RP = 39;
    localparam int K_CMD = 0, K_DONE = 1, K_ERR = 2;

    typedef struct {
        int          cyc;
        int          kind;
        int          typ;
        logic [31:0] fld;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'd0;
    logic [35:0] req_addr = '0;
    logic        cmd_valid;
    logic [2:0]  cmd_type;
    logic        cmd_channel;
    logic [2:0]  cmd_bg;
    logic [1:0]  cmd_bank;
    logic [15:0] cmd_row;
    logic [9:0]  cmd_col;
    logic        done;
    logic        err;

    dram_cmd_scheduler #(
        .T_RCD(T_RCD), .T_CL(T_CL), .T_CWL(T_CWL),
        .T_BURST(T_BURST), .T_WR(T_WR), .T_RP(T_RP)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_addr(req_addr),
        .cmd_valid(cmd_valid), .cmd_type(cmd_type), .cmd_channel(cmd_channel),
        .cmd_bg(cmd_bg), .cmd_bank(cmd_bank), .cmd_row(cmd_row), .cmd_col(cmd_col),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int  cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    ev_t exp_q[$];
    int  rdy_lo = 0, rdy_hi = 0;   // req_ready expected low in cycles [rdy_lo, rdy_hi)
    int  n_tests = 0, n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] fld_of(input logic [35:0] a);
        return {a[6], a[9:7], a[11:10], a[33:18], a[17:12], a[5:2]};
    endfunction

    task automatic push(input int c, input int k, input int t, input logic [31:0] f);
        ev_t e;
        e.cyc = c; e.kind = k; e.typ = t; e.fld = f;
        exp_q.push_back(e);
    endtask

    // Reference: absolute cycle of every output event for an access accepted on edge e.
    task automatic model_accept(input int e, input logic [1:0] op, input logic [35:0] addr);
        logic [31:0] f;
        int c1, pre, dn;
        bit wr;
        if (op == 2'd3) begin
            push(e + 1, K_ERR, 0, 32'd0);
            rdy_lo = e + 1;
            rdy_hi = e + 2;
        end else begin
            f   = fld_of(addr);
            wr  = (op == 2'd1);
            c1  = e + 3 + T_RCD;
            pre = wr ? c1 + T_CWL + T_BURST + T_WR : c1 + T_CL + T_BURST;
            dn  = pre + T_RP;
            push(e + 1, K_CMD, 0, f);
            push(e + 2, K_CMD, 1, f);
            push(c1 - 1, K_CMD, wr ? 4 : 2, f);
            push(c1, K_CMD, wr ? 5 : 3, f);
            push(pre, K_CMD, 6, f);
            push(dn, K_DONE, 0, 32'd0);
            rdy_lo = e + 1;
            rdy_hi = dn;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [1:0] op, input logic [35:0] addr);
        bit acc = 0;
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        for (int k = 0; k < 3000 && !acc; k++) begin
            if (req_ready === 1'b1) begin
                model_accept(cyc, op, addr);
                acc = 1;
            end
            step();
        end
        req_valid = 1'b0;
        if (!acc) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout at cycle %0d: got no req_ready, expected a handshake", cyc);
        end
    endtask

    task automatic do_reset(input int n);
        int  c0 = cyc;
        ev_t keep[$];
        rst_n     = 1'b0;
        req_valid = 1'b0;
        foreach (exp_q[i]) if (exp_q[i].cyc <= c0) keep.push_back(exp_q[i]);
        exp_q = keep;
        if (rdy_hi <= c0) rdy_lo = c0 + 1;
        rdy_hi = c0 + n + 1;
        repeat (n) step();
        rst_n = 1'b1;
    endtask

    // Monitor: one observed event per cycle, matched against the queue head.
    logic [31:0] obs_f;
    int          obs_k;
    ev_t         e_h;
    always @(negedge clk) begin
        if (cyc >= 1) begin
            check("req_ready", 64'(req_ready), 64'(!(cyc >= rdy_lo && cyc < rdy_hi)));
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                e_h = exp_q.pop_front();
                n_tests++;
                n_fail++;
                $display("FAIL missing_event at cycle %0d: got nothing, expected kind %0d type %0d due cycle %0d",
                         cyc, e_h.kind, e_h.typ, e_h.cyc);
            end
            obs_f = {cmd_channel, cmd_bg, cmd_bank, cmd_row, cmd_col};
            if (cmd_valid === 1'b1 || done === 1'b1 || err === 1'b1) begin
                obs_k = (cmd_valid === 1'b1) ? K_CMD : (done === 1'b1) ? K_DONE : K_ERR;
                if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_event at cycle %0d: got kind %0d type %0d, expected none",
                             cyc, obs_k, cmd_type);
                end else begin
                    e_h = exp_q.pop_front();
                    check("event_kind", 64'(obs_k), 64'(e_h.kind));
                    if (e_h.kind == K_CMD) begin
                        check("cmd_type", 64'(cmd_type), 64'(e_h.typ));
                        check("cmd_fields", 64'(obs_f), 64'(e_h.fld));
                    end
                end
            end else begin
                check("idle_fields", 64'({cmd_type, obs_f}), 64'(0));
            end
        end
    end

    logic [63:0] r;
    initial begin
        do_reset(3);
        send(2'd0, 36'h0_02AC_3AD0);
        send(2'd1, 36'h0_02AC_3AD0);
        repeat (3) step();
        send(2'd0, 36'h1_2345_6789);
        send(2'd2, 36'h3_FFFF_FFFC);
        send(2'd3, 36'h0_0000_1000);
        send(2'd0, 36'h0_0ABC_DEF0);
        repeat (2) step();
        send(2'd0, 36'h0_5555_AAAA);
        repeat (60) step();
        do_reset(1);
        send(2'd1, 36'h0_AAAA_5555);
        for (int i = 0; i < 30; i++) begin
            r = {$urandom, $urandom};
            repeat ($urandom_range(0, 3)) step();
            send(2'($urandom_range(0, 3)), r[35:0]);
            if ($urandom_range(0, 7) == 0) begin
                repeat ($urandom_range(0, 200)) step();
                do_reset(int'($urandom_range(1, 3)));
            end
        end
        for (int k = 0; k < 3000 && exp_q.size() > 0; k++) step();
        repeat (3) step();
        check("drain_empty", 64'(exp_q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
